// File: rtl/video_pkg.sv
// video_pkg -- shared definitions for the scanline double-buffer path.
// Used by row_buffer_scheduler, its bank_port_mux instances and the row drawer,
// so row geometry, pixel width and scheduler state encoding agree everywhere.
package video_pkg;

    localparam int ROW_WIDTH = 480;  // pixels per scanline
    localparam int PIXEL_W   = 24;   // bits per pixel
    localparam int ADDR_W    = 9;    // column address width (covers ROW_WIDTH)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAW  = 2'd2
    } sched_state_t;

    // Column index of the last pixel in a row of the given width.
    function automatic logic [ADDR_W-1:0] last_col(input int row_width);
        return ADDR_W'(row_width - 1);
    endfunction

endpackage

// File: rtl/row_buffer_scheduler_bank_port_mux.sv
// bank_port_mux -- drives one row-buffer RAM port.
// When the bank is the front bank the port is a pure scanout read
// (addr = scan_addr, wren = 0); otherwise it carries the back-bank
// access chosen by the scheduler (clear or drawer write).
// Ports:
//   is_front   in   1        this bank is currently being scanned out
//   scan_addr  in   ADDR_W   scanout read column
//   back_addr  in   ADDR_W   back-bank address (clear counter or drawer)
//   back_data  in   PIXEL_W  back-bank write data
//   back_wren  in   1        back-bank write enable
//   ram_addr   out  ADDR_W   RAM port address
//   ram_data   out  PIXEL_W  RAM port write data
//   ram_wren   out  1        RAM port write enable
module bank_port_mux #(
    parameter int PIXEL_W = video_pkg::PIXEL_W
) (
    input  logic                        is_front,
    input  logic [video_pkg::ADDR_W-1:0] scan_addr,
    input  logic [video_pkg::ADDR_W-1:0] back_addr,
    input  logic [PIXEL_W-1:0]          back_data,
    input  logic                        back_wren,
    output logic [video_pkg::ADDR_W-1:0] ram_addr,
    output logic [PIXEL_W-1:0]          ram_data,
    output logic                        ram_wren
);

    // NOTE: every output gets a value before any branch so no latch is inferred.
    always_comb begin
        ram_addr = back_addr;
        ram_data = back_data;
        ram_wren = back_wren;
        if (is_front) begin
            ram_addr = scan_addr;
            ram_data = '0;
            ram_wren = 1'b0;
        end
    end

endmodule

// File: rtl/row_buffer_scheduler.sv
// row_buffer_scheduler -- ping-pong row buffer control for scanline rendering.
// On each line_start the banks swap roles: the freshly drawn back bank becomes
// the front (scanout) bank, and the new back bank is cleared to bg_color over
// ROW_WIDTH cycles. After the clear, swap tells the row drawer to start, and
// drawer writes pass straight through to the back bank until the next line.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   line_start                    1-cycle pulse at start of a scanline
//   bg_color                      pixel written during clear
//   drw_addr/drw_data/drw_wren    row drawer write port (honoured in DRAW only)
//   swap                          1-cycle pulse: drawer may start next row
//   scan_addr / scan_data         scanout read; data one cycle after address
//   ram_a_* / ram_b_*             bank RAM ports (1-cycle read latency)
//   front_bank                    0: A is front, 1: B is front
//   overrun                       sticky: line_start arrived mid-clear
module row_buffer_scheduler #(
    parameter int ROW_WIDTH = video_pkg::ROW_WIDTH,
    parameter int PIXEL_W   = video_pkg::PIXEL_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         line_start,
    input  logic [PIXEL_W-1:0]           bg_color,
    input  logic [video_pkg::ADDR_W-1:0] drw_addr,
    input  logic [PIXEL_W-1:0]           drw_data,
    input  logic                         drw_wren,
    output logic                         swap,
    input  logic [video_pkg::ADDR_W-1:0] scan_addr,
    output logic [PIXEL_W-1:0]           scan_data,
    output logic [video_pkg::ADDR_W-1:0] ram_a_addr,
    output logic [PIXEL_W-1:0]           ram_a_data,
    output logic                         ram_a_wren,
    input  logic [PIXEL_W-1:0]           ram_a_q,
    output logic [video_pkg::ADDR_W-1:0] ram_b_addr,
    output logic [PIXEL_W-1:0]           ram_b_data,
    output logic                         ram_b_wren,
    input  logic [PIXEL_W-1:0]           ram_b_q,
    output logic                         front_bank,
    output logic                         overrun
);

    import video_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_COL = last_col(ROW_WIDTH);

    sched_state_t      state_q;
    logic [ADDR_W-1:0] clear_cnt_q;
    logic              front_bank_q;
    logic              swap_q;
    logic              overrun_q;
    logic              scan_sel_q;

    logic [ADDR_W-1:0]  back_addr;
    logic [PIXEL_W-1:0] back_data;
    logic               back_wren;

    // Scheduler FSM. Any line_start restarts the clear from column 0 with the
    // banks swapped; arriving before the clear finished is flagged as overrun.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            clear_cnt_q  <= '0;
            front_bank_q <= 1'b0;
            swap_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            swap_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DRAW: begin
                    if (line_start) begin
                        front_bank_q <= ~front_bank_q;
                        clear_cnt_q  <= '0;
                        state_q      <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (line_start) begin
                        overrun_q    <= 1'b1;
                        front_bank_q <= ~front_bank_q;
                        clear_cnt_q  <= '0;
                    end else if (clear_cnt_q == LAST_COL) begin
                        // Last column is being written this cycle.
                        swap_q      <= 1'b1;
                        clear_cnt_q <= '0;
                        state_q     <= ST_DRAW;
                    end else begin
                        clear_cnt_q <= clear_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read-data select follows front_bank one cycle late, matching RAM latency,
    // so a read issued just before a toggle returns data from the old bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scan_sel_q <= 1'b0;
        else        scan_sel_q <= front_bank_q;
    end

    // Back-bank access source: clear counter, drawer, or nothing.
    always_comb begin
        back_addr = '0;
        back_data = '0;
        back_wren = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                back_addr = clear_cnt_q;
                back_data = bg_color;
                back_wren = 1'b1;
            end
            ST_DRAW: begin
                back_addr = drw_addr;
                back_data = drw_data;
                back_wren = drw_wren;
            end
            default: ;
        endcase
    end

    bank_port_mux #(.PIXEL_W(PIXEL_W)) u_bank_a (
        .is_front  (~front_bank_q),
        .scan_addr (scan_addr),
        .back_addr (back_addr),
        .back_data (back_data),
        .back_wren (back_wren),
        .ram_addr  (ram_a_addr),
        .ram_data  (ram_a_data),
        .ram_wren  (ram_a_wren)
    );

    bank_port_mux #(.PIXEL_W(PIXEL_W)) u_bank_b (
        .is_front  (front_bank_q),
        .scan_addr (scan_addr),
        .back_addr (back_addr),
        .back_data (back_data),
        .back_wren (back_wren),
        .ram_addr  (ram_b_addr),
        .ram_data  (ram_b_data),
        .ram_wren  (ram_b_wren)
    );

    assign scan_data  = scan_sel_q ? ram_b_q : ram_a_q;
    assign swap       = swap_q;
    assign front_bank = front_bank_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_row_buffer_scheduler.sv
// Testbench for row_buffer_scheduler. Stimulus is driven one cycle at a time;
// a reference model works from "cycles since the last line_start" and pushes
// the expected cycle outcome into a queue that a negedge monitor pops.
module tb_row_buffer_scheduler;

    import video_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               line_start;
    logic [PIXEL_W-1:0] bg_color;
    logic [ADDR_W-1:0]  drw_addr;
    logic [PIXEL_W-1:0] drw_data;
    logic               drw_wren;
    logic               swap;
    logic [ADDR_W-1:0]  scan_addr;
    logic [PIXEL_W-1:0] scan_data;
    logic [ADDR_W-1:0]  ram_a_addr, ram_b_addr;
    logic [PIXEL_W-1:0] ram_a_data, ram_b_data;
    logic               ram_a_wren, ram_b_wren;
    logic [PIXEL_W-1:0] ram_a_q = '0;
    logic [PIXEL_W-1:0] ram_b_q = '0;
    logic               front_bank;
    logic               overrun;

    always #5 clk = ~clk;

    row_buffer_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .bg_color   (bg_color),
        .drw_addr   (drw_addr),
        .drw_data   (drw_data),
        .drw_wren   (drw_wren),
        .swap       (swap),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .ram_a_addr (ram_a_addr),
        .ram_a_data (ram_a_data),
        .ram_a_wren (ram_a_wren),
        .ram_a_q    (ram_a_q),
        .ram_b_addr (ram_b_addr),
        .ram_b_data (ram_b_data),
        .ram_b_wren (ram_b_wren),
        .ram_b_q    (ram_b_q),
        .front_bank (front_bank),
        .overrun    (overrun)
    );

    // Bank RAMs with one cycle of read latency.
    logic [PIXEL_W-1:0] mem_a [512];
    logic [PIXEL_W-1:0] mem_b [512];

    always @(posedge clk) begin
        if (ram_a_wren) mem_a[ram_a_addr] <= ram_a_data;
        ram_a_q <= mem_a[ram_a_addr];
        if (ram_b_wren) mem_b[ram_b_addr] <= ram_b_data;
        ram_b_q <= mem_b[ram_b_addr];
    end

    // Expected outcome of one clock cycle.
    typedef struct packed {
        logic               a_wren;
        logic               a_chk;
        logic [ADDR_W-1:0]  a_addr;
        logic [PIXEL_W-1:0] a_data;
        logic               b_wren;
        logic               b_chk;
        logic [ADDR_W-1:0]  b_addr;
        logic [PIXEL_W-1:0] b_data;
        logic               swap;
        logic               front;
        logic               ovr;
        logic               scan_vld;
        logic [PIXEL_W-1:0] scan;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks   = 0;
    int n_fail     = 0;
    int swaps_seen = 0;
    int swaps_exp  = 0;

    // Reference model: picture of the line in progress.
    bit                 m_idle  = 1'b1;  // no line_start since reset
    int                 m_s     = 0;     // cycle of the last line_start
    int                 m_c     = 0;     // current cycle index
    bit                 m_front = 1'b0;
    bit                 m_ovr   = 1'b0;
    bit                 prev_ls = 1'b0;
    bit                 pend_vld = 1'b0;
    logic [PIXEL_W-1:0] pend = '0;
    logic [PIXEL_W-1:0] shadow [2][512];

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_a[i]     = '0;
            mem_b[i]     = '0;
            shadow[0][i] = '0;
            shadow[1][i] = '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Drive one cycle and predict its outcome.
    task automatic step(input bit ls, input bit rst);
        exp_t              e;
        int                d;
        bit                wr;
        bit                bchk;
        logic [ADDR_W-1:0] baddr;
        logic [PIXEL_W-1:0] wdata;
        @(posedge clk);
        #1;
        rst_n      = !rst;
        line_start = ls;
        if (ls) bg_color = PIXEL_W'($urandom);
        drw_wren  = 1'($urandom_range(0, 1));
        drw_addr  = ADDR_W'($urandom_range(0, ROW_WIDTH - 1));
        drw_data  = PIXEL_W'($urandom);
        scan_addr = (ls || prev_ls) ? ADDR_W'(5) : ADDR_W'($urandom_range(0, ROW_WIDTH - 1));
        d = m_c - m_s;
        // Fixed drawer write: lands once drawing, dropped while clearing.
        if (!m_idle && (d == 100 || d == 600)) begin
            drw_wren = 1'b1;
            drw_addr = ADDR_W'(10);
            drw_data = 24'hFF0000;
        end
        e     = '0;
        wr    = 1'b0;
        bchk  = 1'b0;
        baddr = '0;
        wdata = '0;
        if (rst) begin
            m_idle   = 1'b1;
            m_front  = 1'b0;
            m_ovr    = 1'b0;
            pend_vld = 1'b0;
        end else begin
            e.scan_vld = pend_vld;
            e.scan     = pend;
            if (!m_idle && d <= ROW_WIDTH) begin
                // Clear phase: cycle d after line_start writes column d-1.
                wr    = 1'b1;
                bchk  = 1'b1;
                baddr = ADDR_W'(d - 1);
                wdata = bg_color;
            end else if (!m_idle) begin
                e.swap = (d == ROW_WIDTH + 1);
                bchk   = 1'b1;
                baddr  = drw_addr;
                wr     = drw_wren;
                wdata  = drw_data;
            end
            if (!m_front) begin
                e.a_chk = 1'b1; e.a_addr = scan_addr;
                e.b_wren = wr;  e.b_chk = bchk; e.b_addr = baddr; e.b_data = wdata;
            end else begin
                e.b_chk = 1'b1; e.b_addr = scan_addr;
                e.a_wren = wr;  e.a_chk = bchk; e.a_addr = baddr; e.a_data = wdata;
            end
            pend     = shadow[m_front][scan_addr];
            pend_vld = 1'b1;
            if (wr) shadow[!m_front][baddr] = wdata;
            if (e.swap) swaps_exp++;
            if (ls) begin
                if (!m_idle && d <= ROW_WIDTH) m_ovr = 1'b1;
                m_front = !m_front;
                m_s     = m_c;
                m_idle  = 1'b0;
            end
        end
        e.front = m_front ^ (ls && !rst);  // registered: still the old value this cycle
        e.ovr   = rst ? 1'b0 : (m_ovr & ~(ls && !m_idle && d <= ROW_WIDTH && m_s == m_c && !e.ovr ? 1'b1 : 1'b0)) ;
        prev_ls = ls;
        m_c++;
        exp_q.push_back(e);
    endtask

    // A line_start followed by gap-1 quiet cycles.
    task automatic line(input int gap);
        step(1'b1, 1'b0);
        repeat (gap - 1) step(1'b0, 1'b0);
    endtask

    // Monitor: compare each cycle's outputs against the model's prediction.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("a_wren", 32'(ram_a_wren), 32'(mon_e.a_wren));
            if (mon_e.a_chk)  check("a_addr", 32'(ram_a_addr), 32'(mon_e.a_addr));
            if (mon_e.a_wren) check("a_data", 32'(ram_a_data), 32'(mon_e.a_data));
            check("b_wren", 32'(ram_b_wren), 32'(mon_e.b_wren));
            if (mon_e.b_chk)  check("b_addr", 32'(ram_b_addr), 32'(mon_e.b_addr));
            if (mon_e.b_wren) check("b_data", 32'(ram_b_data), 32'(mon_e.b_data));
            check("swap", 32'(swap), 32'(mon_e.swap));
            check("front_bank", 32'(front_bank), 32'(mon_e.front));
            check("overrun", 32'(overrun), 32'(mon_e.ovr));
            if (mon_e.scan_vld) check("scan_data", 32'(scan_data), 32'(mon_e.scan));
            if (swap) swaps_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        line_start = 1'b0;
        bg_color   = '0;
        drw_addr   = '0;
        drw_data   = '0;
        drw_wren   = 1'b0;
        scan_addr  = '0;
        repeat (3) step(1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0);    // idle: drawer writes must be ignored
        line(800);                      // two full lines
        line(800);
        line(481);                      // next line_start coincides with swap
        line(201);                      // next line_start at clear column 200
        line(600);
        step(1'b1, 1'b0);               // clear, then reset at column 300
        repeat (300) step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) line($urandom_range(300, 900));
        repeat (10) step(1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("swap_count", 32'(swaps_seen), 32'(swaps_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/row_buffer_scheduler.md
ROW_BUFFER_SCHEDULER -- requirements
Module: row_buffer_scheduler

Interface
REQ-001 Parameter ROW_WIDTH, default 480, SHALL set the pixels per row and the clear length.
REQ-002 Parameter PIXEL_W, default 24, SHALL set the pixel data width.
REQ-003 clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 line_start  in  1  one-cycle pulse marking the start of a new scanline.
REQ-006 bg_color  in  PIXEL_W  background pixel written during clear.
REQ-007 drw_addr, drw_data, drw_wren  in  9/PIXEL_W/1  row drawer write port.
REQ-008 swap  out  1  one-cycle pulse to the row drawer to start the next row.
REQ-009 scan_addr  in  9  scanout read column.
REQ-010 scan_data  out  PIXEL_W  front-bank pixel, valid 1 cycle after scan_addr.
REQ-011 ram_a_addr/ram_a_data/ram_a_wren  out  9/PIXEL_W/1, ram_a_q  in  PIXEL_W  bank A port (1-cycle read latency); ram_b_* identical for bank B.
REQ-012 front_bank  out  1  0 = A is front (scanout), 1 = B is front.
REQ-013 overrun  out  1  sticky: line_start arrived before clear completed.

Function
REQ-014 The FSM SHALL have states IDLE, CLEAR, DRAW.
REQ-015 IDLE: on line_start, toggle front_bank, clear_cnt := 0, go CLEAR.
REQ-016 CLEAR: each cycle, back bank SHALL be written bg_color at address clear_cnt with wren=1; clear_cnt increments.
REQ-017 When clear_cnt == ROW_WIDTH-1 is written, FSM SHALL go DRAW and assert swap for exactly the next cycle.
REQ-018 DRAW: back-bank addr/data/wren SHALL equal drw_addr/drw_data/drw_wren combinationally.
REQ-019 Outside DRAW, drw_wren SHALL be ignored (no back-bank write from drawer).
REQ-020 line_start in DRAW SHALL toggle front_bank, reset clear_cnt, and go CLEAR (normal line turnover).
REQ-021 line_start in CLEAR SHALL set overrun, toggle front_bank, and restart clear at 0.
REQ-022 Front bank port SHALL have wren=0 and addr=scan_addr at all times.
REQ-023 scan_data SHALL select ram_a_q or ram_b_q using front_bank registered by one cycle, so a toggle never mixes banks within a read.
REQ-024 clear_cnt SHALL be 9 bits; never exceeds ROW_WIDTH-1.
REQ-025 overrun SHALL clear only on reset.
REQ-026 line_start coincident with swap SHALL be handled per REQ-020; swap still pulses that cycle.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, front_bank=0, clear_cnt=0, swap=0, overrun=0, both wren=0, scan_data select=0.
REQ-028 Reset mid-CLEAR or mid-DRAW SHALL abort with no further writes; first line_start after release starts normally.

Structure
REQ-029 ROW_WIDTH, PIXEL_W and the state encoding SHALL live in shared package video_pkg, also used by the row drawer.
REQ-030 Bank port muxing SHALL be one sub-module, bank_port_mux, instantiated once per bank.

Verification
REQ-031 Reset, one line_start -> front_bank=1, bank A written bg_color at 0..479 over 480 cycles, swap 1 cycle after last write.
REQ-032 DRAW, drw_wren=1 addr=10 data=0xFF0000 -> back bank addr 10 written; same stimulus during CLEAR -> no drawer write.
REQ-033 line_start at clear_cnt=200 -> overrun=1, clear restarts at 0, front_bank toggles again.
REQ-034 Scanout reads addr 5 across a front_bank toggle -> scan_data from the old bank for the read issued before the toggle.
REQ-035 rst_n low at clear_cnt=300 -> all wren 0 immediately, state IDLE, overrun 0.
REQ-036 Two full lines of 800 cycles -> swap pulses exactly twice, overrun stays 0.
